// File: rtl/l2_vc_requester_if.sv
// VC / pmem handshake bundle between the L2 requester (master) and the
// victim cache plus physical-memory port (slave).
interface l2_vc_requester_if #(
  parameter int ADDR_W = 12
);
  logic              L2_read;
  logic              L2_write;
  logic [ADDR_W-1:0] L2_address;
  logic              L2_dirty_bit;
  logic              VC_ack;
  logic              foh;
  logic              VC_write;
  logic              L2toPmem_busy;
  logic              pmem_read;
  logic [ADDR_W-1:0] pmem_address;
  logic              pmem_resp;

  modport master (
    output L2_read, L2_write, L2_address, L2_dirty_bit,
    output L2toPmem_busy, pmem_read, pmem_address,
    input  VC_ack, foh, VC_write, pmem_resp
  );

  modport slave (
    input  L2_read, L2_write, L2_address, L2_dirty_bit,
    input  L2toPmem_busy, pmem_read, pmem_address,
    output VC_ack, foh, VC_write, pmem_resp
  );
endinterface

// File: rtl/l2_vc_requester.sv
// L2-side initiator for the L2 <-> victim-cache protocol: probes the VC on a
// miss, falls through to pmem on foh, then evicts the L2 victim into the VC.
// All request outputs are Moore decodes of the registered state.
module l2_vc_requester #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              i_victim_valid,
  input  logic              i_victim_dirty,
  input  logic [ADDR_W-1:0] i_victim_addr,
  l2_vc_requester_if.master bus,
  output logic              o_fill_done,
  output logic              o_fill_src,
  output logic [CNT_W-1:0]  o_vc_hit_cnt,
  output logic [CNT_W-1:0]  o_pmem_fill_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_VC_RD   = 3'd1;
  localparam logic [2:0] S_PM_WAIT = 3'd2;
  localparam logic [2:0] S_PM_RD   = 3'd3;
  localparam logic [2:0] S_GAP1    = 3'd4;
  localparam logic [2:0] S_VC_WR   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              r_done_q;
  logic              r_fill_src;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_pm_cnt;
  logic [ADDR_W-1:0] r_miss_addr;
  logic [ADDR_W-1:0] r_vic_addr;
  logic              r_vic_valid;
  logic              r_vic_dirty;
  logic              w_capture;
  logic              w_vc_hit;
  logic              w_pm_fill;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // The miss_req that was still high through DONE must not retrigger a fill.
  assign w_capture = (r_state == S_IDLE) && i_miss_req && !r_done_q;
  assign w_vc_hit  = (r_state == S_VC_RD) && bus.VC_ack;
  assign w_pm_fill = (r_state == S_PM_RD) && bus.pmem_resp;

  // Next-state decode; VC_ack takes priority over foh in VC_RD.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_capture)          w_next = S_VC_RD;
      S_VC_RD:   if (bus.VC_ack)         w_next = S_GAP1;
                 else if (bus.foh)       w_next = S_PM_WAIT;
      S_PM_WAIT: if (!bus.VC_write)      w_next = S_PM_RD;
      S_PM_RD:   if (bus.pmem_resp)      w_next = S_GAP1;
      S_GAP1:    w_next = r_vic_valid ? S_VC_WR : S_DONE;
      S_VC_WR:   if (bus.VC_ack)         w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Control state, fill source and statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_done_q   <= 1'b0;
      r_fill_src <= 1'b0;
      r_hit_cnt  <= '0;
      r_pm_cnt   <= '0;
    end else begin
      r_state  <= w_next;
      r_done_q <= (r_state == S_DONE);
      if (w_vc_hit) begin
        r_fill_src <= 1'b0;
        r_hit_cnt  <= sat_inc(r_hit_cnt);
      end else if (w_pm_fill) begin
        r_fill_src <= 1'b1;
        r_pm_cnt   <= sat_inc(r_pm_cnt);
      end
    end
  end

  // Snapshot of the miss and victim line, frozen for the whole transaction.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_miss_addr <= i_miss_addr;
      r_vic_addr  <= i_victim_addr;
      r_vic_valid <= i_victim_valid;
      r_vic_dirty <= i_victim_dirty;
    end
  end

  assign bus.L2_read       = (r_state == S_VC_RD);
  assign bus.L2_write      = (r_state == S_VC_WR);
  assign bus.L2_address    = (r_state == S_VC_WR) ? r_vic_addr : r_miss_addr;
  assign bus.L2_dirty_bit  = (r_state == S_VC_WR) && r_vic_dirty;
  assign bus.pmem_read     = (r_state == S_PM_RD);
  assign bus.L2toPmem_busy = (r_state == S_PM_RD);
  assign bus.pmem_address  = r_miss_addr;
  assign o_fill_done       = (r_state == S_DONE);
  assign o_fill_src        = r_fill_src;
  assign o_vc_hit_cnt      = r_hit_cnt;
  assign o_pmem_fill_cnt   = r_pm_cnt;

endmodule

// File: doc/l2_vc_requester.md
Name: l2_vc_requester

Overview:
- L2-side initiator for the L2 <-> victim-cache (VC) protocol.
- On an L2 miss it first probes the VC with a read. If the VC falls through (foh), it fetches the line from physical memory. It then pushes the L2 victim line into the VC with a write.
- Sits between the L2 cache control and the VC control. It also arbitrates L2 pmem reads against VC write-backs.

Parameters:
- ADDR_W, 12, line-address width (matches the VC's 12-bit L2_address/wb_address).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- miss_req  in  1  L2 control requests a fill; held until fill_done.
- miss_addr  in  ADDR_W  line address of the missing line.
- victim_valid  in  1  L2 set has a valid line to evict.
- victim_dirty  in  1  dirty bit of the evicted line.
- victim_addr  in  ADDR_W  line address of the evicted line.
- L2_read  out  1  read request to VC.
- L2_write  out  1  write (eviction) request to VC.
- L2_address  out  ADDR_W  address presented to VC.
- L2_dirty_bit  out  1  dirty bit sent with L2_write.
- VC_ack  in  1  VC completed current request.
- foh  in  1  VC read miss; fall through to pmem.
- VC_write  in  1  VC is writing back to pmem.
- L2toPmem_busy  out  1  L2 owns the pmem port.
- pmem_read  out  1  pmem read strobe.
- pmem_address  out  ADDR_W  pmem read address.
- pmem_resp  in  1  pmem read complete.
- fill_done  out  1  one-cycle pulse: line available to L2.
- fill_src  out  1  source of the line: 0 = VC, 1 = pmem; valid with fill_done.
- vc_hit_cnt  out  CNT_W  saturating count of VC read hits.
- pmem_fill_cnt  out  CNT_W  saturating count of pmem fills.

Behaviour:
- Reset (async, rst_n low):
  - State -> IDLE.
  - All request outputs, fill_done, fill_src and L2toPmem_busy go to 0.
  - Both counters clear to 0.
  - Reset mid-transaction abandons the transaction; no fill_done is issued.
- All outputs are registered-state decodes (Moore), except L2_address/pmem_address, which mux from the registered addresses.
- miss_addr and victim_* are captured into registers on the IDLE -> VC_RD transition. Later changes on those inputs are ignored.
- States and transitions:
  - IDLE: when miss_req = 1 and fill_done was not asserted in the previous cycle -> VC_RD.
  - VC_RD: L2_read = 1, L2_address = miss reg.
    - VC_ack -> GAP1, fill_src reg <= 0, vc_hit_cnt++.
    - else foh -> PM_WAIT.
    - else hold (VC busy in write-back).
    - VC_ack and foh are never both 1; if they are, VC_ack wins.
  - PM_WAIT: no request. When VC_write = 0 -> PM_RD. Must not drive pmem while the VC is writing back.
  - PM_RD: pmem_read = 1, L2toPmem_busy = 1, pmem_address = miss reg.
    - Stays until pmem_resp -> GAP1, with fill_src reg <= 1 and pmem_fill_cnt++.
  - GAP1: one idle cycle with all requests low. This honours the VC's one-cycle post-ack break.
    - -> VC_WR if victim_valid reg = 1, else -> DONE.
  - VC_WR: L2_write = 1, L2_address = victim reg, L2_dirty_bit = victim_dirty reg.
    - Holds until VC_ack -> DONE. The VC may stall indefinitely during its own write-back, and requests must stay stable.
  - DONE: fill_done = 1 for exactly one cycle, fill_src valid -> IDLE.
- Request rules:
  - L2_read and L2_write are never both 1.
  - A request, once raised, stays high with a stable address until VC_ack (or foh for reads).
- Latency:
  - VC hit, no victim: miss_req -> fill_done = 4 cycles (IDLE, VC_RD, GAP1, DONE), given a same-cycle VC_ack.
  - VC hit with victim: 5 cycles.
- Counters saturate at 2^CNT_W - 1 and do not wrap.
- A miss_req held high through DONE does not start a new transaction in the following IDLE cycle. This prevents double-fill; L2 control must drop miss_req after fill_done.

Test Plan:
- VC hit, no victim: miss_addr = 0x0A5, victim_valid = 0, VC_ack in the first VC_RD cycle -> L2_read for 1 cycle at address 0x0A5; fill_done with fill_src = 0 at cycle 4; vc_hit_cnt = 1.
- VC miss with dirty victim: foh in VC_RD, VC_write = 0, pmem_resp after 5 cycles -> pmem_read/L2toPmem_busy high 5 cycles at 0x0A5; one gap cycle; L2_write with L2_dirty_bit = 1 at victim_addr 0x3F0 until VC_ack; fill_done with fill_src = 1; pmem_fill_cnt = 1.
- VC write-back contention: foh received while VC_write = 1 for 7 cycles -> pmem_read stays 0 those 7 cycles and rises the cycle after VC_write falls.
- VC stall on eviction: VC_ack withheld 10 cycles in VC_WR -> L2_write, L2_address and L2_dirty_bit stay stable all 10 cycles; no fill_done until 1 cycle after the ack.
- Async reset in PM_RD: rst_n low mid-cycle -> pmem_read, L2toPmem_busy and counters go to 0 immediately; after release with miss_req = 1, a fresh VC_RD is issued.
- Saturation: with CNT_W = 2, perform 5 VC hits -> vc_hit_cnt reads 3 and stays 3.
